// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer and its divider core.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  localparam int DIV_STEPS = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_WB   = 3'd4
  } state_t;

  // Ops whose operands are interpreted as two's complement.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider, one quotient bit per step. Operands are unsigned
// magnitudes; sign handling is done by the parent.
module muldiv_div_core
  import muldiv_pkg::*;
#(
  parameter int W     = 32,
  parameter int STEPS = DIV_STEPS
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_quo,
  output logic [W-1:0] o_rem,
  output logic         o_done
);

  localparam int CW = $clog2(STEPS + 1);

  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_div;
  logic [CW-1:0] r_cnt;
  logic [W:0]    w_trial;
  logic          w_ge;

  // Shift next dividend bit into the partial remainder and try the subtract.
  // Since rem < divisor, the shifted value is < 2*divisor, so the top bit of
  // the W+1-bit difference is a clean "borrow" flag.
  always_comb begin
    w_trial = {r_rem, r_quo[W-1]} - {1'b0, r_div};
    w_ge    = ~w_trial[W];
  end

  // o_done flags the step that produces the final quotient bit, so the
  // parent can leave DIV without an extra idle cycle.
  assign o_done = i_step && (r_cnt == CW'(STEPS - 1));
  assign o_quo  = r_quo;
  assign o_rem  = r_rem;

  // Load clears the remainder and parks the dividend in the quotient shifter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_div <= i_divisor;
      r_cnt <= '0;
    end else if (i_step) begin
      if (w_ge) begin
        r_rem <= w_trial[W-1:0];
        r_quo <= {r_quo[W-2:0], 1'b1};
      end else begin
        r_rem <= {r_rem[W-2:0], r_quo[W-1]};
        r_quo <= {r_quo[W-2:0], 1'b0};
      end
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage multiply/divide controller. Owns every HiLo write: sequences the
// registered multiplier and the restoring divider, and stalls HiLo-dependent
// instructions until the write has landed.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [2:0]            i_op,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  input  logic                  i_read_req,
  input  logic                  i_flush,
  input  logic [2*DATA_W-1:0]   i_hilo_read,
  output logic                  o_hilo_en,
  output logic [2*DATA_W-1:0]   o_hilo_write,
  output logic                  o_busy,
  output logic                  o_stall
);

  localparam int CNT_W = 8;

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [2*DATA_W-1:0] r_prod;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_quo;
  logic [DATA_W-1:0]   r_rem;
  logic [2*DATA_W-1:0] r_hold;

  logic                w_accept;
  logic                w_b_zero;
  logic                w_in_sgn;
  logic                w_op_sgn;
  logic [DATA_W-1:0]   w_dvd_mag;
  logic [DATA_W-1:0]   w_dvs_mag;
  logic                w_div_load;
  logic                w_div_step;
  logic                w_div_done;
  logic [DATA_W-1:0]   w_div_quo;
  logic [DATA_W-1:0]   w_div_rem;
  logic [2*DATA_W-1:0] w_ma;
  logic [2*DATA_W-1:0] w_mb;
  logic [2*DATA_W-1:0] w_prod;
  logic [2*DATA_W-1:0] w_wb_data;

  assign w_accept = (r_state == S_IDLE) && i_start && !i_flush;
  assign w_b_zero = (i_b == '0);
  assign w_in_sgn = is_signed_op(i_op);
  assign w_op_sgn = is_signed_op(r_op);

  // Divider works on magnitudes; signs are reapplied in FIX.
  always_comb begin
    w_dvd_mag = (w_in_sgn && i_a[DATA_W-1]) ? (DATA_W'(0) - i_a) : i_a;
    w_dvs_mag = (w_in_sgn && i_b[DATA_W-1]) ? (DATA_W'(0) - i_b) : i_b;
  end

  assign w_div_load = w_accept && is_div_op(i_op) && !w_b_zero;
  assign w_div_step = (r_state == S_DIV);

  muldiv_div_core #(
    .W     (DATA_W),
    .STEPS (DIV_STEPS)
  ) u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_div_load),
    .i_step     (w_div_step),
    .i_dividend (w_dvd_mag),
    .i_divisor  (w_dvs_mag),
    .o_quo      (w_div_quo),
    .o_rem      (w_div_rem),
    .o_done     (w_div_done)
  );

  // Extend operands to 2*DATA_W; the low half of the wide product is the
  // exact signed or unsigned product, so no wider multiplier is needed.
  always_comb begin
    w_ma   = {{DATA_W{w_op_sgn & r_a[DATA_W-1]}}, r_a};
    w_mb   = {{DATA_W{w_op_sgn & r_b[DATA_W-1]}}, r_b};
    w_prod = w_ma * w_mb;
  end

  // Next-state logic; flush aborts anything not yet committed to WB.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (is_mul_op(i_op))      w_next = S_MUL;
          else if (is_div_op(i_op)) w_next = w_b_zero ? S_WB : S_DIV;
          else                      w_next = S_WB;
        end
      end
      S_MUL:   if (r_cnt == '0) w_next = S_WB;
      S_DIV:   if (w_div_done)  w_next = S_FIX;
      S_FIX:   w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (i_flush && (r_state != S_IDLE) && (r_state != S_WB))
      w_next = S_IDLE;
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Operand capture, multiplier pipeline, divide result fix-up and
  // write-data hold register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_prod <= '0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_hold <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= i_op;
        r_a   <= i_a;
        r_b   <= i_b;
        r_cnt <= CNT_W'(MUL_LAT - 1);
        if (is_div_op(i_op) && w_b_zero) begin
          r_quo <= '1;
          r_rem <= i_a;
        end
      end
      if (r_state == S_MUL) begin
        r_prod <= w_prod;
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
      // MIN_INT / -1 wraps naturally: magnitude quotient 0x80000000 negates
      // to itself.
      if (r_state == S_FIX) begin
        r_quo <= (w_op_sgn && (r_a[DATA_W-1] ^ r_b[DATA_W-1])) ?
                 (DATA_W'(0) - w_div_quo) : w_div_quo;
        r_rem <= (w_op_sgn && r_a[DATA_W-1]) ? (DATA_W'(0) - w_div_rem) : w_div_rem;
      end
      if (r_state == S_WB) r_hold <= w_wb_data;
    end
  end

  // Write-back data mux by captured op.
  always_comb begin
    w_wb_data = r_prod;
    case (r_op)
      OP_MULT, OP_MULTU: w_wb_data = r_prod;
      OP_MADD:           w_wb_data = i_hilo_read + r_prod;
      OP_MSUB:           w_wb_data = i_hilo_read - r_prod;
      OP_DIV, OP_DIVU:   w_wb_data = {r_rem, r_quo};
      OP_MTHI:           w_wb_data = {r_a, i_hilo_read[DATA_W-1:0]};
      OP_MTLO:           w_wb_data = {i_hilo_read[2*DATA_W-1:DATA_W], r_a};
      default:           w_wb_data = r_prod;
    endcase
  end

  assign o_hilo_en    = (r_state == S_WB);
  assign o_hilo_write = o_hilo_en ? w_wb_data : r_hold;
  assign o_busy       = (r_state != S_IDLE);
  assign o_stall      = o_busy && (i_start || i_read_req);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer. "Cycle k" is the k-th cycle after the
// accepting edge; outputs are sampled on the falling edge inside each cycle.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        read_req;
  logic        flush;
  logic [63:0] hilo_rd;
  logic        hilo_en;
  logic [63:0] hilo_wr;
  logic        busy;
  logic        stall;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011,
                         MADD = 3'b100, MSUB = 3'b101, MTHI = 3'b110, MTLO = 3'b111;

  muldiv_sequencer #(.DATA_W(32), .MUL_LAT(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_op         (op),
    .i_a          (a),
    .i_b          (b),
    .i_read_req   (read_req),
    .i_flush      (flush),
    .i_hilo_read  (hilo_rd),
    .o_hilo_en    (hilo_en),
    .o_hilo_write (hilo_wr),
    .o_busy       (busy),
    .o_stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present an op for one edge; returns just after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Sample cycles 1..n: first HiLoEn cycle and data, HiLoEn count, Busy count.
  task automatic watch(input int n, output int en_cyc, output int en_cnt,
                       output logic [63:0] data, output int busy_cnt);
    en_cyc = 0; en_cnt = 0; data = '0; busy_cnt = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (hilo_en) begin
        en_cnt++;
        if (en_cyc == 0) begin en_cyc = c; data = hilo_wr; end
      end
      if (busy) busy_cnt++;
    end
  endtask

  int          ec, en, bc, sc;
  logic [63:0] d, d2;
  int          ec2;
  logic        s34, s35;

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    read_req = 1'b0; flush = 1'b0; hilo_rd = '0;
    repeat (2) @(negedge clk);
    check("rst_en",    {63'd0, hilo_en}, 64'd0);
    check("rst_wr",    hilo_wr,          64'd0);
    check("rst_busy",  {63'd0, busy},    64'd0);
    check("rst_stall", {63'd0, stall},   64'd0);
    rst = 1'b0;

    // MULT -3 * 7 = -21
    issue(MULT, 32'hFFFFFFFD, 32'd7);
    watch(8, ec, en, d, bc);
    check("mult_en_cyc", ec, 5);
    check("mult_en_cnt", en, 1);
    check("mult_data",   d, 64'hFFFFFFFF_FFFFFFEB);
    check("mult_busy",   bc, 5);
    check("mult_hold",   hilo_wr, 64'hFFFFFFFF_FFFFFFEB);

    // MULTU max * max
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    watch(8, ec, en, d, bc);
    check("multu_data", d, 64'hFFFFFFFE_00000001);

    // DIV -7 / 2 = -3 rem -1
    issue(DIV, 32'hFFFFFFF9, 32'd2);
    watch(38, ec, en, d, bc);
    check("div_en_cyc", ec, 34);
    check("div_en_cnt", en, 1);
    check("div_data",   d, {32'hFFFFFFFF, 32'hFFFFFFFD});

    // DIVU 7 / 2 = 3 rem 1
    issue(DIVU, 32'd7, 32'd2);
    watch(38, ec, en, d, bc);
    check("divu_en_cyc", ec, 34);
    check("divu_data",   d, {32'h1, 32'h3});

    // MIN_INT / -1 wraps
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    watch(38, ec, en, d, bc);
    check("div_ovf_data", d, {32'h0, 32'h80000000});

    // DIV 7 / -2 = -3 rem 1 (remainder follows dividend sign)
    issue(DIV, 32'd7, 32'hFFFFFFFE);
    watch(38, ec, en, d, bc);
    check("div_negb_data", d, {32'h1, 32'hFFFFFFFD});

    // Divide by zero
    issue(DIVU, 32'd5, 32'd0);
    watch(4, ec, en, d, bc);
    check("div0_en_cyc", ec, 1);
    check("div0_data",   d, {32'h5, 32'hFFFFFFFF});

    // MADD / MSUB / MTLO / MTHI
    hilo_rd = 64'h1;
    issue(MADD, 32'd2, 32'd3);
    watch(8, ec, en, d, bc);
    check("madd_data", d, 64'h7);

    hilo_rd = 64'h0;
    issue(MSUB, 32'd1, 32'd1);
    watch(8, ec, en, d, bc);
    check("msub_data", d, 64'hFFFFFFFF_FFFFFFFF);

    hilo_rd = 64'h5_00000006;
    issue(MTLO, 32'hAB, 32'd0);
    watch(3, ec, en, d, bc);
    check("mtlo_en_cyc", ec, 1);
    check("mtlo_data",   d, 64'h5_000000AB);

    issue(MTHI, 32'h12, 32'd0);
    watch(3, ec, en, d, bc);
    check("mthi_data", d, 64'h12_00000006);
    hilo_rd = '0;

    // ReadReq held from cycle 2 of a divide
    issue(DIVU, 32'd7, 32'd2);
    sc = 0; s34 = 1'b0; s35 = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (stall) sc++;
      if (c == 34) s34 = stall;
      if (c == 35) s35 = stall;
      if (c == 1) read_req = 1'b1;
    end
    read_req = 1'b0;
    check("rd_stall_cnt", sc, 33);
    check("rd_stall_34",  {63'd0, s34}, 64'd1);
    check("rd_stall_35",  {63'd0, s35}, 64'd0);

    // Back-to-back: second op held on Start during a MULT
    @(negedge clk);
    start = 1'b1; op = MULT; a = 32'd2; b = 32'd3;
    @(posedge clk);
    #1 op = MULTU; a = 32'd4; b = 32'd5;
    sc = 0; ec = 0; ec2 = 0; d = '0; d2 = '0; s35 = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c <= 5 && stall) sc++;
      if (c == 6) s35 = stall;
      if (hilo_en) begin
        if (ec == 0) begin ec = c; d = hilo_wr; end
        else if (ec2 == 0) begin ec2 = c; d2 = hilo_wr; end
      end
      if (c == 6) begin @(posedge clk); #1 start = 1'b0; end
    end
    check("b2b_stall_cnt", sc, 5);
    check("b2b_stall_6",   {63'd0, s35}, 64'd0);
    check("b2b_first",     d, 64'd6);
    check("b2b_second_cyc", ec2, 11);
    check("b2b_second",    d2, 64'd20);

    // Flush in cycle 10 of a divide
    issue(DIVU, 32'd7, 32'd2);
    en = 0; s35 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (hilo_en) en++;
      if (c == 11) s35 = busy;
      if (c == 10) flush = 1'b1;
      if (c == 11) flush = 1'b0;
    end
    check("flush_busy_11", {63'd0, s35}, 64'd0);
    check("flush_no_en",   en, 0);

    // Async reset mid-MUL
    issue(MULT, 32'd9, 32'd9);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; read_req = 1'b1; op = MULT;
    #1;
    check("pre_rst_stall", {63'd0, stall}, 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",  {63'd0, busy},    64'd0);
    check("mid_rst_stall", {63'd0, stall},   64'd0);
    check("mid_rst_en",    {63'd0, hilo_en}, 64'd0);
    start = 1'b0; read_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue(MULT, 32'd5, 32'd6);
    watch(8, ec, en, d, bc);
    check("post_rst_en_cyc", ec, 5);
    check("post_rst_data",   d, 64'd30);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
